// File: rtl/seven_segment_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : seven_segment_reader_if
// Purpose  : Event handshake between the 7-segment reader and its consumer.
//            The reader presents a decoded display change (digit, blank or
//            invalid classification) with valid; the consumer takes it on a
//            clock edge while ready is high.
// Signals  : valid   - event pending (master -> slave)
//            ready   - consumer accepts on this edge (slave -> master)
//            digit   - decoded BCD digit, 4'hF for blank/invalid
//            blank   - event pattern is all segments off
//            invalid - event pattern is neither a digit nor blank
// Revision : 1.0 - initial release
// ============================================================================
interface seven_segment_reader_if;
  logic       valid;
  logic       ready;
  logic [3:0] digit;
  logic       blank;
  logic       invalid;

  modport master (
    output valid,
    output digit,
    output blank,
    output invalid,
    input  ready
  );

  modport slave (
    input  valid,
    input  digit,
    input  blank,
    input  invalid,
    output ready
  );
endinterface
`default_nettype wire

// File: rtl/seven_segment_reader.sv
`default_nettype none
// ============================================================================
// Module   : seven_segment_reader
// Purpose  : Samples an active-low 7-segment bus, waits until a pattern has
//            been stable for STABLE_CYCLES clocks, decodes it back to a BCD
//            digit (or blank / invalid) and reports each change of the
//            displayed value as one handshake event.
// Ports    : clk         - system clock, rising edge
//            rst_n       - synchronous active-low reset
//            seg[6:0]    - segment bus, active-low, [6]=a ... [0]=g
//            overrun_clr - clears the sticky overrun flag
//            overrun     - sticky: a qualified change was lost during HOLD
//            out         - event handshake (master side)
// Revision : 1.0 - initial release
// ============================================================================
module seven_segment_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic [6:0]            seg,
  input  wire logic                  overrun_clr,
  output logic                       overrun,
  seven_segment_reader_if.master     out
);

  localparam int             CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]  C_MAX    = CW'(STABLE_CYCLES);
  localparam logic [6:0]     C_BLANK  = 7'h7F;

  typedef enum logic [0:0] {
    TRACK = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [6:0]      seg_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic [6:0]      last_reported;
  logic            qualified;
  logic            fresh;
  logic            load;
  logic            drop;
  logic            ovr_set;
  logic [3:0]      dec_digit;
  logic            dec_blank;
  logic            dec_invalid;

  // Stability counter next value: restarts whenever the incoming sample
  // differs from the registered one, otherwise counts up and saturates.
  always_comb begin
    cnt_d = cnt_q;
    if (seg != seg_q) begin
      cnt_d = '0;
    end else if (cnt_q != C_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Qualification is judged on the counter value being written this edge,
  // so the event is issued on the very edge the counter saturates. When
  // seg matches seg_q the pattern to report is seg_q itself.
  assign qualified = (seg == seg_q) && (cnt_d == C_MAX);
  assign fresh     = qualified && (seg_q != last_reported);

  // Pattern decode of the registered sample.
  always_comb begin
    dec_digit   = 4'hF;
    dec_blank   = 1'b0;
    dec_invalid = 1'b0;
    case (seg_q)
      7'b0000001: dec_digit = 4'd0;
      7'b1001111: dec_digit = 4'd1;
      7'b0010010: dec_digit = 4'd2;
      7'b0000110: dec_digit = 4'd3;
      7'b1001100: dec_digit = 4'd4;
      7'b0100100: dec_digit = 4'd5;
      7'b0100000: dec_digit = 4'd6;
      7'b0001111: dec_digit = 4'd7;
      7'b0000000: dec_digit = 4'd8;
      7'b0000100: dec_digit = 4'd9;
      7'b1111111: dec_blank = 1'b1;
      default:    dec_invalid = 1'b1;
    endcase
  end

  // FSM next-state and control strobes.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    drop    = 1'b0;
    ovr_set = 1'b0;
    case (state_q)
      TRACK: begin
        if (fresh) begin
          load    = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Acceptance takes priority: a change qualifying on the accept edge
        // is picked up from TRACK one edge later (counter stays saturated).
        if (out.ready) begin
          drop    = 1'b1;
          state_d = TRACK;
        end else if (fresh) begin
          ovr_set = 1'b1;
        end
      end
      default: state_d = TRACK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= TRACK;
      seg_q         <= C_BLANK;
      cnt_q         <= '0;
      last_reported <= C_BLANK;
      out.valid     <= 1'b0;
      out.digit     <= 4'h0;
      out.blank     <= 1'b0;
      out.invalid   <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg;
      cnt_q   <= cnt_d;

      if (load) begin
        out.valid     <= 1'b1;
        out.digit     <= dec_digit;
        out.blank     <= dec_blank;
        out.invalid   <= dec_invalid;
        last_reported <= seg_q;
      end else if (drop) begin
        out.valid     <= 1'b0;
      end

      // Set beats clear when both happen on the same edge.
      if (ovr_set) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
